// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and registered result out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;

  modport master (
    output start, A, B,
    input  busy, done, Sum, Carry
  );

  modport slave (
    input  start, A, B,
    output busy, done, Sum, Carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two halfAdder
// cells, a carry flop, and operand/sum shift registers sequenced by a small FSM.

module halfAdder (
  input  logic a,
  input  logic b,
  output logic Sum,
  output logic Carry
);
  assign Sum   = a ^ b;
  assign Carry = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             c_next;

  // Full-adder slice on the current LSBs and the looped-back carry.
  halfAdder ha1 (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .Sum   (ha1_s),
    .Carry (ha1_c)
  );

  halfAdder ha2 (
    .a     (ha1_s),
    .b     (c),
    .Sum   (ha2_s),
    .Carry (ha2_c)
  );

  assign c_next = ha1_c | ha2_c;

  // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the first result bit.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next = ha2_s;
    end else begin : g_sum_wn
      assign sum_next = {ha2_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.Sum   <= '0;
      bus.Carry <= 1'b0;
      c         <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.A;
            b_sr     <= bus.B;
            c        <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          c      <= c_next;
          cnt    <= cnt + CW'(1);
          // Final bit: publish result together with the last carry-out.
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            bus.done  <= 1'b1;
            bus.Sum   <= sum_next;
            bus.Carry <= c_next;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed 8-bit vectors plus a 1-bit
// instance; expected results queued at issue, checked when done is seen.
`timescale 1ns/1ps

module tb_serial_adder;
  typedef struct {
    logic [7:0] sum;
    logic       carry;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst8;
  logic rst1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done8_cnt = 0;
  int   done1_cnt = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", 32'(bus8.Sum), 32'(e8.sum));
        chk("carry8", 32'(bus8.Carry), 32'(e8.carry));
        chk("latency8", 32'(cyc), 32'(e8.due));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      done1_cnt++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done1_unexpected: got done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("sum1", 32'(bus1.Sum), 32'(e1.sum));
        chk("carry1", 32'(bus1.Carry), 32'(e1.carry));
        chk("latency1", 32'(cyc), 32'(e1.due));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] s, input logic co);
    exp_t e;
    bus8.start = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    e.sum   = s;
    e.carry = co;
    e.due   = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic s, input logic co);
    exp_t e;
    bus1.start = 1'b1;
    bus1.A     = a;
    bus1.B     = b;
    e.sum   = 8'(s);
    e.carry = co;
    e.due   = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus8.done === 1'b1) return;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(bus8.done), 32'd1);
  endtask

  task automatic wait_done1(input string name);
    for (int i = 0; i < 10; i++) begin
      if (bus1.done === 1'b1) return;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(bus1.done), 32'd1);
  endtask

  initial begin
    int nbusy;
    int d0;
    rst8 = 1'b1;
    rst1 = 1'b1;
    bus8.start = 1'b0;
    bus8.A = '0;
    bus8.B = '0;
    bus1.start = 1'b0;
    bus1.A = '0;
    bus1.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(bus8.busy), 32'd0);
    chk("rst_done8", 32'(bus8.done), 32'd0);
    chk("rst_sum8", 32'(bus8.Sum), 32'd0);
    chk("rst_carry8", 32'(bus8.Carry), 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    chk("rst_sum1", 32'(bus1.Sum), 32'd0);
    rst8 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Zero plus zero.
    issue8(8'h00, 8'h00, 8'h00, 1'b0);
    wait_done8("t1");
    @(negedge clk);

    // Full carry ripple, and busy window length.
    issue8(8'hFF, 8'h01, 8'h00, 1'b1);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk("busy_len", 32'(nbusy), 32'd9);

    // start held during busy with new operands is ignored.
    d0 = done8_cnt;
    bus8.start = 1'b1;
    bus8.A = 8'hA5;
    bus8.B = 8'h5A;
    e8.sum = 8'hFF;
    e8.carry = 1'b0;
    e8.due = cyc + 9;
    q8.push_back(e8);
    @(negedge clk);
    bus8.A = 8'h01;
    bus8.B = 8'h01;
    wait_done8("t3");
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("single_done", 32'(done8_cnt - d0), 32'd1);

    // Reset at the 4th SHIFT edge aborts the addition.
    d0 = done8_cnt;
    issue8(8'h7F, 8'h7F, 8'hFE, 1'b0);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_sum", 32'(bus8.Sum), 32'd0);
    chk("abort_carry", 32'(bus8.Carry), 32'd0);
    rst8 = 1'b0;
    void'(q8.pop_back());
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done8_cnt - d0), 32'd0);
    issue8(8'h7F, 8'h7F, 8'hFE, 1'b0);
    wait_done8("t4");
    @(negedge clk);

    // Back-to-back: restart in the first IDLE cycle; old result holds.
    issue8(8'h3C, 8'hC4, 8'h00, 1'b1);
    wait_done8("t5a");
    @(negedge clk);
    issue8(8'h12, 8'h34, 8'h46, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("hold_sum", 32'(bus8.Sum), 32'h00);
      chk("hold_carry", 32'(bus8.Carry), 32'd1);
      @(negedge clk);
    end
    wait_done8("t5b");
    @(negedge clk);

    // One-bit instance, all operand pairs.
    issue1(1'b0, 1'b0, 1'b0, 1'b0);
    wait_done1("w1a");
    @(negedge clk);
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    wait_done1("w1b");
    @(negedge clk);
    issue1(1'b0, 1'b1, 1'b1, 1'b0);
    wait_done1("w1c");
    @(negedge clk);
    issue1(1'b1, 1'b1, 1'b0, 1'b1);
    wait_done1("w1d");
    repeat (4) @(negedge clk);
    chk("done1_total", 32'(done1_cnt), 32'd4);

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
